// File: rtl/load_store_unit.sv
// Load/store unit: latches a decoded memory op, runs a req/gnt/rvalid access to data memory,
// lane-aligns store data/byte enables and formats load data, stalling the pipeline until done.
module load_store_unit #(
   parameter int XLEN    = 32,
   parameter int TIMEOUT = 16
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            mem_read_i,
   input  logic            mem_write_i,
   input  logic [3:0]      mem_write_mask_i,
   input  logic [2:0]      funct3_i,
   input  logic [XLEN-1:0] addr_i,
   input  logic [XLEN-1:0] store_data_i,
   output logic            dmem_req_o,
   output logic            dmem_we_o,
   output logic [XLEN-1:0] dmem_addr_o,
   output logic [3:0]      dmem_be_o,
   output logic [XLEN-1:0] dmem_wdata_o,
   input  logic            dmem_gnt_i,
   input  logic            dmem_rvalid_i,
   input  logic [XLEN-1:0] dmem_rdata_i,
   output logic [XLEN-1:0] load_data_o,
   output logic            done_o,
   output logic            err_o,
   output logic            stall_o
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, RESP} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            we_q, we_d;
   logic [XLEN-1:0] addr_q, addr_d;
   logic [3:0]      be_q, be_d;
   logic [XLEN-1:0] wdata_q, wdata_d;
   logic [2:0]      funct3_q, funct3_d;
   logic [1:0]      off_q, off_d;
   logic            err_q, err_d;
   logic [XLEN-1:0] load_data_q, load_data_d;

   logic            start, illegal, timeout;
   logic [3:0]      base_mask;
   logic [XLEN-1:0] shifted, fmt;

   assign start   = mem_read_i | mem_write_i;
   assign timeout = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

   always_comb begin
      illegal = 1'b0;
      if (mem_write_i) begin
         if (funct3_i > 3'b010 || mem_write_mask_i == 4'b0000) illegal = 1'b1;
      end else if (funct3_i == 3'b011 || funct3_i == 3'b110 || funct3_i == 3'b111) begin
         illegal = 1'b1;
      end
      if (funct3_i[1:0] == 2'b01 && addr_i[0]) illegal = 1'b1;
      if (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00) illegal = 1'b1;
   end

   // Loads carry no mask from decode, so their enables come from the access size.
   always_comb begin
      base_mask = 4'b1111;
      if (mem_write_i) base_mask = mem_write_mask_i;
      else if (funct3_i[1:0] == 2'b00) base_mask = 4'b0001;
      else if (funct3_i[1:0] == 2'b01) base_mask = 4'b0011;
   end

   assign shifted = dmem_rdata_i >> {off_q, 3'b000};

   always_comb begin
      case (funct3_q)
         3'b000:  fmt = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         3'b001:  fmt = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         3'b100:  fmt = {{(XLEN-8){1'b0}}, shifted[7:0]};
         3'b101:  fmt = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: fmt = shifted;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      we_d        = we_q;
      addr_d      = addr_q;
      be_d        = be_q;
      wdata_d     = wdata_q;
      funct3_d    = funct3_q;
      off_d       = off_q;
      err_d       = err_q;
      load_data_d = load_data_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               we_d        = mem_write_i;
               addr_d      = {addr_i[XLEN-1:2], 2'b00};
               be_d        = base_mask << addr_i[1:0];
               wdata_d     = store_data_i << {addr_i[1:0], 3'b000};
               funct3_d    = funct3_i;
               off_d       = addr_i[1:0];
               err_d       = illegal;
               load_data_d = '0;
               cnt_d       = '0;
               state_d     = illegal ? RESP : REQ;
            end
         end
         REQ: begin
            cnt_d = cnt_q + 1'b1;
            if (dmem_gnt_i) begin
               state_d = WAIT_RSP;
            end else if (timeout) begin
               state_d = RESP;
               err_d   = 1'b1;
            end
         end
         WAIT_RSP: begin
            cnt_d = cnt_q + 1'b1;
            if (dmem_rvalid_i) begin
               state_d = RESP;
               if (!we_q) load_data_d = fmt;
            end else if (timeout) begin
               state_d = RESP;
               err_d   = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         be_q        <= '0;
         wdata_q     <= '0;
         funct3_q    <= '0;
         off_q       <= '0;
         err_q       <= 1'b0;
         load_data_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         be_q        <= be_d;
         wdata_q     <= wdata_d;
         funct3_q    <= funct3_d;
         off_q       <= off_d;
         err_q       <= err_d;
         load_data_q <= load_data_d;
      end
   end

   assign dmem_req_o   = (state_q == REQ);
   assign dmem_we_o    = we_q;
   assign dmem_addr_o  = addr_q;
   assign dmem_be_o    = be_q;
   assign dmem_wdata_o = wdata_q;
   assign load_data_o  = load_data_q;
   assign done_o       = (state_q == RESP);
   assign err_o        = (state_q == RESP) && err_q;
   assign stall_o      = ((state_q == IDLE) && start) || (state_q == REQ) || (state_q == WAIT_RSP);

endmodule
